// File: rtl/bdc_frame_controller_if.sv
// AXI-Stream style bundle shared by the upstream, core-side and core-output-monitor links.
// The monitor modport only observes the handshake and end-of-frame marker.
interface bdc_frame_controller_if #(
    parameter int unsigned DATA_WIDTH = 24
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave (input tdata, input tvalid, input tlast, input tuser, output tready);
    modport monitor (input tvalid, input tready, input tlast);
endinterface

// File: rtl/bdc_frame_controller.sv
// Frame sequencer for the barrel distortion core: forwards one repaired WIDTHxHEIGHT frame
// at a time, waits for the core output to drain, and changes K1 only between frames.
module bdc_frame_controller #(
    parameter int unsigned WIDTH         = 128,
    parameter int unsigned HEIGHT        = 100,
    parameter int unsigned DATA_WIDTH    = 24,
    parameter logic [7:0]  K1_RESET      = 8'hE0,
    parameter int unsigned DRAIN_TIMEOUT = 200000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    bdc_frame_controller_if.slave          s_axis,
    bdc_frame_controller_if.master         c_axis,
    bdc_frame_controller_if.monitor        mon,
    input  logic [7:0]                     cfg_k1_i,
    input  logic                           cfg_k1_wr_i,
    input  logic                           cfg_err_clr_i,
    output logic [7:0]                     core_k1_o,
    output logic                           busy_o,
    output logic [15:0]                    frames_done_o,
    output logic                           err_nosof_o,
    output logic                           err_short_o,
    output logic                           err_long_o,
    output logic                           err_timeout_o
);
    localparam int unsigned NumPix = WIDTH * HEIGHT;
    localparam int unsigned CntW   = (NumPix > 1) ? $clog2(NumPix) : 1;
    localparam int unsigned WdW    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(NumPix - 1);
    localparam logic [WdW-1:0]  WdLast  = WdW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StRun, StPad, StDiscard, StDrain} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [WdW-1:0]  wd_q;
    logic            out_done_q;
    logic [7:0]      k1_shadow_q;
    logic [7:0]      core_k1_q;
    logic [15:0]     frames_done_q;
    logic            err_nosof_q, err_short_q, err_long_q, err_timeout_q;

    logic cnt_is_last;
    logic s_hs, c_hs, mon_hs;

    assign cnt_is_last = (cnt_q == LastCnt);

    // Data path is purely combinational so the core sees zero added latency.
    always_comb begin
        c_axis.tdata  = s_axis.tdata;
        c_axis.tvalid = 1'b0;
        c_axis.tlast  = 1'b0;
        c_axis.tuser  = 1'b0;
        s_axis.tready = 1'b0;
        if (rst_n) begin
            case (state_q)
                StIdle: begin
                    if (s_axis.tuser) begin
                        c_axis.tvalid = s_axis.tvalid;
                        s_axis.tready = c_axis.tready;
                        c_axis.tuser  = 1'b1;
                        c_axis.tlast  = (NumPix == 1);
                    end else begin
                        s_axis.tready = 1'b1;
                    end
                end
                StRun: begin
                    c_axis.tvalid = s_axis.tvalid;
                    s_axis.tready = c_axis.tready;
                    c_axis.tlast  = cnt_is_last;
                end
                StPad: begin
                    c_axis.tdata  = '0;
                    c_axis.tvalid = 1'b1;
                    c_axis.tlast  = cnt_is_last;
                end
                StDiscard: s_axis.tready = 1'b1;
                default: ;
            endcase
        end
    end

    assign s_hs   = s_axis.tvalid & s_axis.tready;
    assign c_hs   = c_axis.tvalid & c_axis.tready;
    assign mon_hs = mon.tvalid & mon.tready & mon.tlast;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wd_q          <= '0;
            out_done_q    <= 1'b0;
            k1_shadow_q   <= K1_RESET;
            core_k1_q     <= K1_RESET;
            frames_done_q <= '0;
            err_nosof_q   <= 1'b0;
            err_short_q   <= 1'b0;
            err_long_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            if (cfg_k1_wr_i) k1_shadow_q <= cfg_k1_i;
            // Clear first so that any error raised below in the same cycle wins.
            if (cfg_err_clr_i) begin
                err_nosof_q   <= 1'b0;
                err_short_q   <= 1'b0;
                err_long_q    <= 1'b0;
                err_timeout_q <= 1'b0;
            end
            if (mon_hs && state_q != StIdle) out_done_q <= 1'b1;

            case (state_q)
                StIdle: begin
                    if (c_hs) begin
                        cnt_q   <= CntW'(1);
                        state_q <= (NumPix == 1) ? StDrain : StRun;
                    end else begin
                        core_k1_q <= k1_shadow_q;
                    end
                    if (s_hs && !s_axis.tuser) err_nosof_q <= 1'b1;
                end
                StRun: begin
                    if (c_hs) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_is_last) begin
                            if (s_axis.tlast) begin
                                state_q <= StDrain;
                            end else begin
                                err_long_q <= 1'b1;
                                state_q    <= StDiscard;
                            end
                        end else if (s_axis.tlast) begin
                            err_short_q <= 1'b1;
                            state_q     <= StPad;
                        end
                    end
                end
                StPad: begin
                    if (c_hs) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_is_last) state_q <= StDrain;
                    end
                end
                StDiscard: begin
                    if (s_hs && s_axis.tlast) state_q <= StDrain;
                end
                StDrain: begin
                    if (out_done_q) begin
                        frames_done_q <= frames_done_q + 16'd1;
                        out_done_q    <= 1'b0;
                        wd_q          <= '0;
                        cnt_q         <= '0;
                        state_q       <= StIdle;
                    end else if (wd_q == WdLast) begin
                        err_timeout_q <= 1'b1;
                        out_done_q    <= 1'b0;
                        wd_q          <= '0;
                        cnt_q         <= '0;
                        state_q       <= StIdle;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core_k1_o     = core_k1_q;
    assign busy_o        = (state_q != StIdle);
    assign frames_done_o = frames_done_q;
    assign err_nosof_o   = err_nosof_q;
    assign err_short_o   = err_short_q;
    assign err_long_o    = err_long_q;
    assign err_timeout_o = err_timeout_q;
endmodule

// File: doc/bdc_frame_controller.md
# bdc_frame_controller

Frame sequencer in front of `barrel_distortion_correction`. Accepts the upstream AXI-Stream pixel stream and forwards exactly one well-formed WIDTH×HEIGHT frame at a time to the core, regenerating tuser/tlast from its own pixel counter. It repairs short frames by zero-padding and truncates long frames. It holds the next frame off until the core's output frame has drained, and applies the K1 distortion coefficient only at frame boundaries.

## Interface
- WIDTH, 128, pixels per line
- HEIGHT, 100, lines per frame
- DATA_WIDTH, 24, pixel width (RGB888)
- K1_RESET, 8'hE0, reset value of K1 shadow and core_k1 (signed 4.4)
- DRAIN_TIMEOUT, 200000, max cycles spent in DRAIN before abort

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_axis_tdata / tvalid / tlast / tuser  in  DATA_WIDTH/1/1/1  upstream stream
- s_axis_tready  out  1  upstream ready
- c_axis_tdata / tvalid / tlast / tuser  out  DATA_WIDTH/1/1/1  stream to core
- c_axis_tready  in  1  core s_axis_tready
- mon_tvalid / mon_tready / mon_tlast  in  1/1/1  tap of core m_axis handshake
- cfg_k1  in  8  new K1 value
- cfg_k1_wr  in  1  write strobe for K1 shadow
- cfg_err_clr  in  1  clears sticky error flags
- core_k1  out  8  K1 presented to core, frozen during a frame
- busy  out  1  state != IDLE
- frames_done  out  16  completed output frames, wraps
- err_nosof / err_short / err_long / err_timeout  out  1 each  sticky errors

## Operation
- N = WIDTH*HEIGHT. The pixel counter `cnt` is clog2(N) bits wide; it increments on each c_axis handshake and is cleared when the FSM enters IDLE.
- IDLE:
  - Every cycle without an SOF handshake: core_k1 <= k1_shadow.
  - Pixels with tuser=1: c_tvalid = s_tvalid, s_tready = c_tready, c_tuser = 1.
  - Pixels with tuser=0: s_tready = 1, c_tvalid = 0. The pixel is dropped and err_nosof is set.
  - On the SOF handshake: cnt <= 1, go to RUN. If N == 1 instead, c_tlast = 1 and go to DRAIN.
- RUN:
  - Pass-through: c_tdata = s_tdata, c_tvalid = s_tvalid, s_tready = c_tready, c_tuser = 0, c_tlast = (cnt == N-1).
  - Upstream tuser mid-frame is ignored.
  - On a handshake with s_tlast and cnt < N-1: set err_short and go to PAD. The pixel is forwarded with c_tlast = 0.
  - On a handshake at cnt == N-1:
    - with s_tlast: go to DRAIN.
    - without s_tlast: set err_long and go to DISCARD.
- PAD: c_tvalid = 1, c_tdata = 0, s_tready = 0, c_tlast = (cnt == N-1). On the handshake at N-1, go to DRAIN.
- DISCARD: s_tready = 1, c_tvalid = 0. On an s_tvalid & s_tlast handshake, go to DRAIN.
- DRAIN: s_tready = 0, c_tvalid = 0. The watchdog counts cycles in DRAIN.
  - When out_done is set: frames_done++, clear out_done, go to IDLE.
  - When the watchdog reaches DRAIN_TIMEOUT: set err_timeout, clear out_done, go to IDLE. frames_done is not incremented.
- out_done flag: set by a mon_tvalid & mon_tready & mon_tlast handshake in any non-IDLE state, so an early core EOF is not lost. It is ignored in IDLE.
- k1_shadow <= cfg_k1 on cfg_k1_wr, in any state. A write in the SOF-handshake cycle or later applies to the next frame.
- Sticky errors: cfg_err_clr clears them. If set and clear occur in the same cycle, set wins.

## Timing
- Reset (async assert, sync deassert use):
  - state = IDLE, cnt = 0, out_done = 0, watchdog = 0.
  - k1_shadow = core_k1 = K1_RESET.
  - frames_done = 0, all err_* = 0, busy = 0.
  - c_tvalid = 0 while rst_n = 0.
- Data path is combinational in IDLE/RUN: zero-cycle latency, no buffering. c_tdata/c_tvalid must stay stable while c_tready is low, as long as upstream obeys AXI.
- busy rises the cycle after the SOF handshake. It falls the cycle after DRAIN exits.
- Reset mid-frame aborts to IDLE immediately. The remaining upstream pixels are then dropped as no-SOF.

## Test plan
- Nominal, WIDTH=128, HEIGHT=100: one 12800-pixel frame with correct tuser/tlast, core drained → c_axis carries 12800 pixels with tuser only on pixel 0 and tlast only on pixel 12799. frames_done = 1, no errors, busy = 0 afterwards.
- Short frame: tlast on pixel 12000 → 799 zero pixels padded, c_tlast on pixel 12799, err_short = 1.
- Long frame: 12900 pixels, tlast on the final one → 12800 forwarded, 100 discarded, err_long = 1. The next frame is accepted normally.
- No SOF: 5 pixels with tuser=0 precede the frame → all 5 dropped, err_nosof = 1, the frame is forwarded intact. cfg_err_clr then clears the flag to 0.
- K1 boundary: cfg_k1 = 8'h10 written mid-frame → core_k1 stays 8'hE0 until DRAIN exits, then becomes 8'h10 before the next SOF.
- Timeout: mon_tlast never asserted → after 200000 DRAIN cycles err_timeout = 1, state returns to IDLE, frames_done unchanged.
